// File: rtl/matrix_stream_io.sv
// Streaming load/unload wrapper for the matrix_dot_product core: gathers A then B
// from a valid/ready input stream and returns the captured result on an output stream.
module matrix_stream_io #(
   parameter int M1     = 2,
   parameter int N1     = 2,
   parameter int N2     = 2,
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [M1*N1*DATA_W-1:0]   mat_a,
   output logic [N1*N2*DATA_W-1:0]   mat_b,
   input  logic [M1*N2*DATA_W-1:0]   res,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy
);

   localparam int NA     = M1 * N1;
   localparam int NB     = N1 * N2;
   localparam int NR     = M1 * N2;
   localparam int NAB    = (NA > NB) ? NA : NB;
   localparam int NMAX   = (NAB > NR) ? NAB : NR;
   localparam int IDX_W  = $clog2(NMAX) + 1;
   localparam int WCNT_W = $clog2(LAT) + 1;

   localparam logic [IDX_W-1:0]  A_LAST = IDX_W'(NA - 1);
   localparam logic [IDX_W-1:0]  B_LAST = IDX_W'(NB - 1);
   localparam logic [IDX_W-1:0]  R_LAST = IDX_W'(NR - 1);
   localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(LAT - 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, SEND} state_t;

   state_t                   state;
   state_t                   next_state;
   logic [IDX_W-1:0]         idx;
   logic [IDX_W-1:0]         idx_nxt;
   logic [WCNT_W-1:0]        wcnt;
   logic [M1*N2*DATA_W-1:0]  res_buf;
   logic                     in_xfer;
   logic                     out_xfer;

   assign idx_nxt  = idx + 1'b1;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD_A;
      else     state <= next_state;
   end

   // Handshake strobes are pure state decodes; in_ready is also masked by rst
   // so nothing is offered while the block is being held in reset.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      case (state)
         LOAD_A: begin
            in_ready = !rst;
            if (in_xfer && idx == A_LAST) next_state = LOAD_B;
         end
         LOAD_B: begin
            in_ready = !rst;
            if (in_xfer && idx == B_LAST) next_state = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (wcnt == W_LAST) next_state = SEND;
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (idx == R_LAST);
            if (out_xfer && out_last) next_state = LOAD_A;
         end
         default: next_state = LOAD_A;
      endcase
   end

   // out_data is preloaded with element 0 when the result is captured, then
   // advanced one element per accepted transfer, so SEND never shows a stale value.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         wcnt     <= '0;
         mat_a    <= '0;
         mat_b    <= '0;
         res_buf  <= '0;
         out_data <= '0;
      end else begin
         case (state)
            LOAD_A: begin
               if (in_xfer) begin
                  mat_a[idx*DATA_W +: DATA_W] <= in_data;
                  idx <= (idx == A_LAST) ? '0 : idx_nxt;
               end
            end
            LOAD_B: begin
               if (in_xfer) begin
                  mat_b[idx*DATA_W +: DATA_W] <= in_data;
                  if (idx == B_LAST) begin
                     idx  <= '0;
                     wcnt <= '0;
                  end else begin
                     idx <= idx_nxt;
                  end
               end
            end
            WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (wcnt == W_LAST) begin
                  res_buf  <= res;
                  out_data <= res[DATA_W-1:0];
                  idx      <= '0;
               end
            end
            SEND: begin
               if (out_xfer) begin
                  if (idx == R_LAST) begin
                     idx <= '0;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= res_buf[idx_nxt*DATA_W +: DATA_W];
                  end
               end
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_stream_io.sv
// Directed bench for matrix_stream_io: table of 2x2 load/unload runs plus
// hand-written reset and LAT=3 latency sequences.
module tb_matrix_stream_io;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  in_data,  in_data3;
   logic         in_valid, in_valid3;
   logic         in_ready, in_ready3;
   logic [127:0] mat_a, mat_b, res, mat_a3, mat_b3, res3;
   logic [31:0]  out_data, out_data3;
   logic         out_valid, out_valid3;
   logic         out_ready, out_ready3;
   logic         out_last, out_last3;
   logic         busy, busy3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic [3:0][31:0] exp;
      bit               stall;
      bit               bp;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   matrix_stream_io #(.M1(2), .N1(2), .N2(2), .DATA_W(32), .LAT(1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mat_a(mat_a), .mat_b(mat_b), .res(res), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy)
   );

   matrix_stream_io #(.M1(2), .N1(2), .N2(2), .DATA_W(32), .LAT(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mat_a(mat_a3), .mat_b(mat_b3), .res(res3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_last(out_last3), .busy(busy3)
   );

   // Stand-in for the compute core: 2x2 Q16.16 matrix product.
   function automatic logic [127:0] matmul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r = '0;
      longint acc;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            acc = 0;
            for (int k = 0; k < 2; k++)
               acc += longint'($signed(a[(i*2+k)*32 +: 32])) * longint'($signed(b[(k*2+j)*32 +: 32]));
            r[(i*2+j)*32 +: 32] = 32'(acc >>> 16);
         end
      return r;
   endfunction

   always_comb res  = matmul(mat_a, mat_b);
   always_comb res3 = matmul(mat_a3, mat_b3);

   function automatic logic [3:0][31:0] mk4(input logic [31:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic expectEq(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      for (int k = 0; k < 8; k++) begin
         if (v.stall) begin
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            @(posedge clk); #1;
         end
         in_data  = (k < 4) ? v.a[k] : v.b[k-4];
         in_valid = 1'b1;
         expectEq("in_ready_load", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic checkOutput(input vec_t v);
      int cyc = 1;   // cycle 0 is the one carrying the final B transfer
      while (!out_valid && cyc < 20) begin
         expectEq("busy_wait", {busy, in_ready}, 2'b10);
         @(posedge clk); #1;
         cyc++;
      end
      expectEq("latency_lat1", cyc, 2);
      expectEq("mat_a_hold", mat_a, v.a);
      expectEq("mat_b_hold", mat_b, v.b);
      for (int i = 0; i < 4; i++) begin
         if (v.bp && i == 2) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               expectEq("bp_valid", out_valid, 1);
               expectEq("bp_data", out_data, v.exp[i]);
            end
         end
         out_ready = 1'b1;
         expectEq("out_valid", out_valid, 1);
         expectEq("out_data", out_data, v.exp[i]);
         expectEq("out_last", out_last, (i == 3));
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      expectEq("after_send", {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      vecs[0] = '{mk4(32'h10000, 32'h20000, 32'h30000, 32'h40000),
                  mk4(32'h10000, 32'h20000, 32'h30000, 32'h40000),
                  mk4(32'h70000, 32'hA0000, 32'hF0000, 32'h160000), 1'b0, 1'b0};
      vecs[1] = '{mk4(32'h10000, 32'h0, 32'h0, 32'h10000),
                  mk4(32'h10000, 32'h20000, 32'h30000, 32'h40000),
                  mk4(32'h10000, 32'h20000, 32'h30000, 32'h40000), 1'b0, 1'b0};
      vecs[2] = '{mk4(32'h20000, 32'h0, 32'h0, 32'hFFFF0000),
                  mk4(32'h30000, 32'h50000, 32'h70000, 32'h90000),
                  mk4(32'h60000, 32'hA0000, 32'hFFF90000, 32'hFFF70000), 1'b1, 1'b0};
      vecs[3] = '{mk4(32'h8000, 32'h0, 32'h0, 32'h8000),
                  mk4(32'h20000, 32'h30000, 32'h50000, 32'h70000),
                  mk4(32'h10000, 32'h18000, 32'h28000, 32'h38000), 1'b0, 1'b1};
      vecs[4] = '{vecs[0].a, vecs[0].b, vecs[0].exp, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expectEq("reset_strobes", {in_ready, out_valid, out_last, busy}, 4'b0000);
      expectEq("reset_out_data", out_data, 0);
      expectEq("reset_mats", {mat_a, mat_b}, 0);
      rst = 1'b0; #1;
      expectEq("ready_after_reset", in_ready, 1);

      // Reset after three A elements, with a fourth on the bus at the reset edge.
      for (int k = 0; k < 3; k++) begin
         in_data = vecs[0].a[k]; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_data = vecs[0].a[3]; rst = 1'b1;
      @(posedge clk); #1;
      expectEq("midload_mat_a", mat_a, 0);
      expectEq("midload_strobes", {in_ready, out_valid, out_last, busy}, 4'b0000);
      rst = 1'b0; in_valid = 1'b0; #1;
      expectEq("midload_ready", in_ready, 1);

      // Runs follow each other with no idle cycle in between.
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v]);
         checkOutput(vecs[v]);
      end

      // Reset while SEND is offering data with out_ready high.
      applyStimulus(vecs[0]);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      expectEq("send_reached", out_valid, 1);
      out_ready = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      expectEq("send_reset_strobes", {in_ready, out_valid, out_last, busy}, 4'b0000);
      expectEq("send_reset_data", out_data, 0);
      expectEq("send_reset_mats", {mat_a, mat_b}, 0);
      rst = 1'b0; out_ready = 1'b0; #1;

      // LAT=3 instance: out_valid appears in the 4th cycle after the final B transfer cycle.
      for (int k = 0; k < 8; k++) begin
         in_data3  = (k < 4) ? vecs[0].a[k] : vecs[0].b[k-4];
         in_valid3 = 1'b1;
         @(posedge clk); #1;
      end
      in_valid3 = 1'b0;
      cyc = 1;
      while (!out_valid3 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      expectEq("latency_lat3", cyc, 4);
      out_ready3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expectEq("lat3_data", {out_valid3, out_last3, out_data3}, {1'b1, (i == 3), vecs[0].exp[i]});
         @(posedge clk); #1;
      end
      expectEq("lat3_done", {in_ready3, busy3}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_stream_io.md
# matrix_stream_io

Streaming front/back end for the `matrix_dot_product` compute core. It accepts matrix elements one per handshake on a valid/ready input stream and assembles operand A, then operand B, into flat registered buses that drive the core. It then waits a fixed compute latency, captures the core's result matrix, and returns it element by element on a valid/ready output stream. It replaces bench-style parallel loading with a synthesizable, sequential load/unload path.

## Interface
Parameters:
- `M1`, default 2: rows of A and of the result.
- `N1`, default 2: columns of A and rows of B (`N1 == M2`).
- `N2`, default 2: columns of B and of the result.
- `DATA_W`, default 32: element width, signed fixed-point Q16.16.
- `LAT`, default 1: core compute latency in cycles, ≥1.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  DATA_W: incoming element, row-major, A elements first, then B elements.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block accepts an element.
- `mat_a`  out  M1\*N1\*DATA_W: flat A to the core; element k occupies bits [k\*DATA_W +: DATA_W].
- `mat_b`  out  N1\*N2\*DATA_W: flat B to the core, same packing.
- `res`  in  M1\*N2\*DATA_W: flat result from the core, same packing.
- `out_data`  out  DATA_W: outgoing result element, row-major.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts an element.
- `out_last`  out  1: the current output element is the final one (index M1\*N2-1).
- `busy`  out  1: high in WAIT and SEND.

## Operation
- FSM states: LOAD_A, LOAD_B, WAIT, SEND. Reset state is LOAD_A.
- Handshake: a transfer occurs on a rising edge where valid && ready.
- LOAD_A:
  - `in_ready` = 1.
  - Each transfer writes `in_data` into `mat_a` element `idx` and increments `idx`.
  - On the transfer with `idx == M1*N1-1`: clear `idx` and go to LOAD_B.
- LOAD_B:
  - Same behaviour into `mat_b`.
  - On the transfer with `idx == N1*N2-1`: clear `idx` and `wcnt`, then go to WAIT.
- WAIT:
  - `in_ready` = 0.
  - `wcnt` increments each cycle. When `wcnt == LAT-1`, latch all of `res` into the internal result buffer, clear `idx`, and go to SEND.
- SEND:
  - `out_valid` = 1 and `out_data` = buffer[`idx`].
  - `out_last` = (`idx == M1*N2-1`).
  - Each transfer increments `idx`.
  - On the transfer with `out_last` set: clear `idx` and go to LOAD_A.
  - `out_valid` stays high and `out_data` stays stable while `out_ready` is low.
- `mat_a` and `mat_b` hold their values through WAIT, SEND, and the next load. Elements are overwritten only as new elements arrive.
- No arithmetic in this block; all elements pass through bit-exact. Index counters are `$clog2(max element count)+1` bits wide, with no wrap beyond the terminal compare.
- `in_valid` asserted outside the load states is ignored; no data is consumed.
- `out_ready` asserted outside SEND is ignored.

## Timing
- Values after a reset edge:
  - State LOAD_A; `idx` = 0 and `wcnt` = 0.
  - `mat_a`, `mat_b` and the result buffer are all zero.
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` deasserts.
- `in_ready`, `out_valid`, `out_last` and `busy` are decoded from state. `out_data` is a registered buffer read.
- Sustained throughput: one element per cycle on input and on output.
- Latency from the final B transfer edge to `out_valid` high is `LAT` + 1 cycles.
- Back-to-back operation: after the final output transfer edge, `in_ready` is 1 in the next cycle.
- Reset mid-operation, in any state, discards partial loads and pending outputs and returns to the reset values on the next edge. `rst` has priority over every handshake on the same edge.

## Test plan
- Basic 2×2, `LAT`=1:
  - Stimulus: stream A = 1,2,3,4 and B = 1,2,3,4, i.e. 0x00010000..0x00040000; model the core as Q16.16 matmul.
  - Required: outputs 0x00070000, 0x000A0000, 0x000F0000, 0x00160000; `out_last` high only on 0x00160000.
- Input stalls: toggle `in_valid` 1/0 every cycle during the load. Required: identical results; each element is captured exactly once.
- Output backpressure: hold `out_ready` = 0 for 5 cycles mid-SEND. Required: `out_data` and `out_valid` stay stable, and no element is dropped or duplicated.
- Latency: set `LAT`=3. Required: `out_valid` rises exactly 4 cycles after the final B transfer.
- Reset mid-operation: assert `rst` after 3 A elements. Required: all outputs return to reset values; a fresh full load then gives the correct result.
- Back-to-back runs: run a second run with A = identity and B = 1,2,3,4 immediately after the first. Required: outputs 0x00010000, 0x00020000, 0x00030000, 0x00040000 with no idle cycle between runs.
